// File: rtl/data_memory_ext.sv
// -----------------------------------------------------------------------------
// data_memory_ext
// Word-organised data memory with byte, halfword and word access. It has a
// fixed-latency request/done handshake and an optional preload.
//
// Each accepted request is held in internal registers. The block then waits
// WAIT_CYCLES extra cycles and performs the access on the commit edge. It
// reports completion with a one-cycle done pulse, and err is valid with done.
// Misaligned accesses, reserved sizes and out-of-range addresses are rejected.
// A rejected access leaves the memory untouched and returns read_data = 0.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, 16..4096)
//   WAIT_CYCLES  extra stall cycles per access (0..15)
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   synchronous active-high reset (memory contents kept)
//   req         in   access request, sampled only while ready = 1
//   we          in   1 = write, 0 = read
//   size        in   00 byte, 01 halfword, 10 word, 11 reserved
//   sign_ext    in   1 sign-extends, 0 zero-extends byte/halfword reads
//   address     in   byte address
//   write_data  in   store data, right-aligned
//   ready       out  idle and able to accept req
//   done        out  one-cycle completion pulse
//   err         out  access rejected (valid with done)
//   read_data   out  load result, held until the next access completes
//
// Build option
//   DMEM_INIT_EN  when defined, the array is preloaded with words 0..4 =
//                 5, 2, 3, 7, 9 and all other words are 0.
// -----------------------------------------------------------------------------
module data_memory_ext #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] read_data
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  count_r;
    logic        we_r;
    logic [1:0]  size_r;
    logic        sext_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        ready_r;
    logic        done_r;
    logic        err_r;
    logic [31:0] rdata_r;

    logic          accept_s;
    logic          commit_s;
    logic          err_s;
    logic [AW-1:0] idx_s;
    logic [31:0]   word_s;
    logic [7:0]    byte_s;
    logic [15:0]   half_s;
    logic [3:0]    be_s;
    logic [31:0]   wd_s;
    logic [31:0]   rd_s;

`ifdef DMEM_INIT_EN
    logic [31:0] mem_r [DEPTH_WORDS] = '{
        0: 32'h0000_0005,
        1: 32'h0000_0002,
        2: 32'h0000_0003,
        3: 32'h0000_0007,
        4: 32'h0000_0009,
        default: 32'h0000_0000
    };
`else
    logic [31:0] mem_r [DEPTH_WORDS];
`endif

    assign accept_s = (state_r == IDLE) && req;
    // Reset on the commit edge must abort the store, so reset gates the commit.
    assign commit_s = (state_r == BUSY) && (count_r == 4'd0) && !reset;

    // Validity of the latched request. Because the depth is a power of two,
    // any set bit above the index field means the address is out of range.
    assign err_s = (size_r == 2'b11) ||
                   ((size_r == 2'b01) && addr_r[0]) ||
                   ((size_r == 2'b10) && (addr_r[1:0] != 2'b00)) ||
                   (|addr_r[31:AW+2]);

    assign idx_s  = addr_r[AW+1:2];
    assign word_s = mem_r[idx_s];

    // Next-state logic for the request/commit/done sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (count_r == 4'd0) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Lane selection, write merge and read extension for the latched request.
    always_comb begin
        be_s = 4'b0000;
        wd_s = wdata_r;
        rd_s = 32'h0000_0000;
        case (addr_r[1:0])
            2'b00:   byte_s = word_s[7:0];
            2'b01:   byte_s = word_s[15:8];
            2'b10:   byte_s = word_s[23:16];
            2'b11:   byte_s = word_s[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_r[1]) begin
            half_s = word_s[31:16];
        end else begin
            half_s = word_s[15:0];
        end
        case (size_r)
            2'b00: begin
                be_s = 4'b0001 << addr_r[1:0];
                wd_s = {4{wdata_r[7:0]}};
                rd_s = {{24{sext_r & byte_s[7]}}, byte_s};
            end
            2'b01: begin
                be_s = addr_r[1] ? 4'b1100 : 4'b0011;
                wd_s = {2{wdata_r[15:0]}};
                rd_s = {{16{sext_r & half_s[15]}}, half_s};
            end
            2'b10: begin
                be_s = 4'b1111;
                wd_s = wdata_r;
                rd_s = word_s;
            end
            default: begin
                be_s = 4'b0000;
                wd_s = wdata_r;
                rd_s = 32'h0000_0000;
            end
        endcase
    end

    // State register, wait counter, request capture and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            count_r <= 4'd0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == IDLE);
            done_r  <= commit_s;
            err_r   <= commit_s && err_s;
            if (accept_s) begin
                count_r <= 4'(WAIT_CYCLES);
                we_r    <= we;
                size_r  <= size;
                sext_r  <= sign_ext;
                addr_r  <= address;
                wdata_r <= write_data;
            end else if ((state_r == BUSY) && (count_r != 4'd0)) begin
                count_r <= count_r - 4'd1;
            end
            if (commit_s) begin
                rdata_r <= (we_r || err_s) ? 32'h0000_0000 : rd_s;
            end
        end
    end

    // Memory array: byte-lane write on a valid committed store; never reset.
    always_ff @(posedge clk) begin
        if (commit_s && we_r && !err_s) begin
            for (int k = 0; k < 4; k++) begin
                if (be_s[k]) begin
                    mem_r[idx_s][8*k +: 8] <= wd_s[8*k +: 8];
                end
            end
        end
    end

    assign ready     = ready_r;
    assign done      = done_r;
    assign err       = err_r;
    assign read_data = rdata_r;

endmodule

// File: doc/data_memory_ext.md
DATA_MEMORY_EXT -- requirements
Module: data_memory_ext

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words (power of two, 16..4096).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 0, giving the extra stall cycles per access (0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 1 bit: access request, sampled only when ready=1.
REQ-006 The block SHALL have port we, input, 1 bit: 1=write, 0=read, sampled with req.
REQ-007 The block SHALL have port size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 The block SHALL have port sign_ext, input, 1 bit: 1 sign-extends, 0 zero-extends byte/half reads.
REQ-009 The block SHALL have port address, input, 32 bits: byte address.
REQ-010 The block SHALL have port write_data, input, 32 bits: store data, right-aligned (lane 0 source).
REQ-011 The block SHALL have port ready, output, 1 bit: high when idle and able to accept req.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse for reads and writes.
REQ-013 The block SHALL have port err, output, 1 bit: valid with done; misaligned, reserved-size or out-of-range access.
REQ-014 The block SHALL have port read_data, output, 32 bits: load result, valid when done=1 and the access was a read.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY and DONE; ready=1 only in IDLE.
REQ-016 In IDLE, req=1 at a rising edge SHALL latch we, size, sign_ext, address and write_data, load the wait counter with WAIT_CYCLES, and enter BUSY.
REQ-017 req while ready=0 SHALL be ignored, with no queuing.
REQ-018 In BUSY, counter>0 SHALL decrement; counter==0 SHALL perform the access on that edge and enter DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 done SHALL therefore be high in the cycle following edge E0+1+WAIT_CYCLES, where E0 is the accept edge; throughput is one access per 3+WAIT_CYCLES cycles.
REQ-021 Word index SHALL be address[log2(DEPTH_WORDS)+1:2]; lanes are little-endian, with byte lane k at bits 8k+7:8k.
REQ-022 err SHALL be set if size=11, if size=01 and address[0]=1, if size=10 and address[1:0]!=0, or if address >= DEPTH_WORDS*4.
REQ-023 An errored access SHALL not modify memory and SHALL return read_data=0.
REQ-024 Byte writes SHALL update only lane address[1:0] with write_data[7:0]; halfword writes SHALL update only lanes address[1]*2+1:address[1]*2 with write_data[15:0]; word writes SHALL update all lanes.
REQ-025 Reads SHALL extract the addressed lane(s), right-align them, and extend to 32 bits per sign_ext; word reads SHALL ignore sign_ext.
REQ-026 read_data SHALL be registered, held from DONE until the next access completes, and SHALL be 0 after a write completes.
REQ-027 done and err SHALL be 0 outside DONE.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE, with ready=1, done=0, err=0, read_data=0 and counter=0, taking priority over all other activity.
REQ-029 reset during BUSY, including the commit edge, SHALL abort the access; no memory write occurs.
REQ-030 reset SHALL NOT clear the memory array.

Configuration
REQ-031 With DMEM_INIT_EN defined, the array SHALL be preloaded at time zero with word[0]=0x00000005, word[1]=0x00000002, word[2]=0x00000003, word[3]=0x00000007 and word[4]=0x00000009; all other words 0.
REQ-032 Without DMEM_INIT_EN, the array SHALL have no initializer; contents before the first write are undefined and the bench must write before reading.

Verification
REQ-033 DMEM_INIT_EN, WAIT_CYCLES=0: read word at 0x4 -> done in the cycle after edge E0+1, read_data=0x00000002, err=0.
REQ-034 DMEM_INIT_EN: write byte 0x80 at 0x9; then lb 0x9 -> 0xFFFFFF80; lbu 0x9 -> 0x00000080; lw 0x8 -> 0x00008003.
REQ-035 Read word at 0x6 -> err=1, read_data=0; a following lw 0x4 returns the unchanged value 0x00000002.
REQ-036 DEPTH_WORDS=256: write 0xDEADBEEF at 0x400 -> err=1; lw 0x0 still returns the prior value.
REQ-037 WAIT_CYCLES=3: req held high continuously -> done high in the cycle after edge E0+4, with ready=0 from E0 until DONE exits; extra req cycles are not queued.
REQ-038 Write word 0x12345678 at 0x10 with reset asserted at edge E0+1 (in BUSY) -> no done pulse; subsequent lw 0x10 returns the old value.
